maj_bist_driver: RTL and testbench
==================================

// Module: maj_bist_driver
// PURPOSE
//  Synthesizable stimulus/response engine for the mapped N-input majority netlist (top, x0..x(N-1) -> y0).
//  Drives vectors into the DUT, computes the golden majority internally and counts mismatches.
//  Sits beside the DUT on silicon/FPGA; it is the hardware counterpart of the exhaustive simulation bench.
//  Exhaustive sweep is infeasible at N=45, so it uses corner, threshold-boundary and LFSR phases.
// PARAMETERS
//  N        45        DUT input count
//  THRESH   23        y_ref = (popcount >= THRESH)
//  NUM_RAND 4096      LFSR vectors in the RAND phase (>=1)
//  SETTLE   1         cycles between applying a vector and sampling y_in (>=1)
//  SEED     45'h1     LFSR seed; a value of 0 is replaced by 1
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous, active-high reset
//  start           in   1      one-cycle pulse; begins a run from IDLE or DONE
//  x_out           out  N      registered vector to DUT x[N-1:0]
//  y_in            in   1      DUT y0
//  busy            out  1      run in progress
//  done            out  1      run finished; held until next start
//  pass            out  1      done && err_count==0
//  err_count       out  16     mismatch count, saturates at 16'hFFFF
//  fail_valid      out  1      first mismatch captured
//  fail_vec        out  N      vector of the first mismatch
// BEHAVIOUR
//  Reset: x_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, state=IDLE, LFSR=SEED.
//  rst mid-run wins over everything; outputs return to reset values on the next edge.
//  FSM: IDLE -start-> CORNER -> BOUND -> RAND -> DONE -start-> CORNER. start while busy is ignored.
//  start from IDLE/DONE clears err_count, fail_*, done, pass; reloads LFSR; busy=1 on the next edge.
//  Vector period P = SETTLE+1 cycles: x_out loads on the first cycle, holds for P cycles;
//   y_in is compared to y_ref(x_out) on the last cycle of the period; the result is registered on that edge.
//  CORNER: 2 vectors: all-zeros, then all-ones.
//  BOUND: for k=0..N-1: W22 = rotl((1<<(THRESH-1))-1, k), then W23 = rotl((1<<THRESH)-1, k); rotation mod N.
//  RAND: NUM_RAND vectors, x_out = LFSR state, LFSR advanced once per vector after load.
//   45-bit Fibonacci LFSR, taps 45,44,42,41 (shift left, feedback into bit 0).
//  Total vectors V = 2 + 2N + NUM_RAND (4188 at defaults); run length = V*P cycles from the first load.
//  Mismatch: err_count++ unless at 16'hFFFF; on the first mismatch fail_vec=x_out and fail_valid=1 (sticky).
//  After the last compare: state=DONE, busy=0, done=1, pass=(err_count_final==0), x_out holds the last vector.
//  y_ref is computed with a popcount of width $clog2(N+1); no truncation is allowed.
// STRUCTURE
//  Package maj_bist_pkg: N, THRESH, PCW=$clog2(N+1), state enum {IDLE,CORNER,BOUND,RAND,DONE},
//   LFSR tap mask, rotl function.
//  Sub-module maj_popcount #(N): combinational adder tree, in[N-1:0] -> cnt[PCW-1:0].
//  Top level: FSM, phase index counter (covers 0..max(2N,NUM_RAND)-1), settle counter, LFSR, result registers.
// TESTING (SETTLE=1, defaults; DUT behavioural = correct maj45 unless noted)
//  1 Correct DUT, start pulse -> done=1 exactly 8376 cycles after the first load; pass=1, err_count=0, fail_valid=0.
//  2 DUT y0 stuck-0 -> fail_vec=all-ones (2nd vector); err_count = 1 + 45 + (RAND vectors with HW>=23).
//  3 DUT threshold 22 (off-by-one) -> fail_vec=45'h3FFFFF (first W22); err_count = 45 + RAND vectors with HW==22.
//  4 DUT y0 inverted -> err_count=4188, fail_vec=45'h0, pass=0.
//  5 rst asserted 100 cycles into a run -> next edge: busy=0, x_out=0, err_count=0; new start reruns with identical results.
//  6 start pulsed while busy -> no effect on sequence or count; start after done clears err_count and fail_valid,
//    then repeats the same sequence.

Source files
------------

// File: rtl/maj_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maj_bist_pkg                                                 |
// | Description : Shared constants, state encoding and vector helpers for the  |
// |               majority-netlist BIST driver.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package maj_bist_pkg;

    localparam int N      = 45;
    localparam int THRESH = 23;
    localparam int PCW    = $clog2(N + 1);
    localparam int ROTW   = $clog2(N);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CORNER = 3'd1,
        ST_BOUND  = 3'd2,
        ST_RAND   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Fibonacci taps 45,44,42,41 expressed over state bits [44:0]
    localparam logic [N-1:0] c_lfsr_taps = 45'h1B00_0000_0000;

    function automatic logic [N-1:0] low_mask(input int unsigned n);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    localparam logic [N-1:0] c_w22 = low_mask(THRESH - 1);
    localparam logic [N-1:0] c_w23 = low_mask(THRESH);

    // Rotate left by k (k < N): upper half of the doubled word after shifting
    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [ROTW-1:0] k);
        logic [2*N-1:0] d;
        d = {v, v} << k;
        return d[2*N-1:N];
    endfunction

endpackage
`default_nettype wire

// File: rtl/maj_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maj_popcount                                                 |
// | Description : Combinational population count built as a balanced binary  |
// |               adder tree over a power-of-two padded leaf set.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module maj_popcount #(
    parameter int N = 45
) (
    input  logic [N-1:0]             in,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int c_pcw = $clog2(N + 1);
    localparam int c_np  = 1 << $clog2(N);

    // Heap layout: node j sums nodes 2j and 2j+1; leaves live at c_np..2*c_np-1
    logic [c_pcw-1:0] w_node [1:2*c_np-1];

    always_comb begin
        for (int i = 1; i < 2 * c_np; i++) begin
            w_node[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            w_node[c_np + i] = c_pcw'(in[i]);
        end
        for (int j = c_np - 1; j >= 1; j--) begin
            w_node[j] = w_node[2*j] + w_node[2*j+1];
        end
    end

    assign cnt = w_node[1];

endmodule
`default_nettype wire

// File: rtl/maj_bist_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maj_bist_driver                                              |
// | Description : Stimulus/response engine for an N-input majority netlist:   |
// |               corner, threshold-boundary and LFSR phases, mismatch count.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module maj_bist_driver
    import maj_bist_pkg::*;
#(
    parameter int           NUM_RAND = 4096,
    parameter int           SETTLE   = 1,
    parameter logic [N-1:0] SEED     = 45'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] x_out,
    input  logic         y_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic         fail_valid,
    output logic [N-1:0] fail_vec
);

    localparam int c_idx_span = (2 * N > NUM_RAND) ? 2 * N : NUM_RAND;
    localparam int c_idx_w    = $clog2(c_idx_span);
    localparam int c_set_w    = $clog2(SETTLE + 1);

    localparam logic [c_idx_w-1:0] c_corner_last = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_bound_last  = c_idx_w'(2 * N - 1);
    localparam logic [c_idx_w-1:0] c_rand_last   = c_idx_w'(NUM_RAND - 1);
    localparam logic [c_set_w-1:0] c_settle_max  = c_set_w'(SETTLE);
    localparam logic [PCW-1:0]     c_thresh      = PCW'(THRESH);
    localparam logic [N-1:0]       c_seed        = (SEED == '0) ? {{(N-1){1'b0}}, 1'b1} : SEED;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   w_idx_nxt;
    logic [c_set_w-1:0]   r_settle;
    logic [N-1:0]         r_lfsr;
    logic [N-1:0]         r_x;
    logic [15:0]          r_err;
    logic                 r_fail_valid;
    logic [N-1:0]         r_fail_vec;
    logic                 r_pass;

    logic                 w_busy;
    logic                 w_period_end;
    logic                 w_load;
    logic                 w_cmp;
    logic                 w_finish;
    logic                 w_start_run;
    logic [ROTW-1:0]      w_rot_k;
    logic [N-1:0]         w_vec;
    logic [PCW-1:0]       w_cnt;
    logic                 w_y_ref;
    logic                 w_mismatch;
    logic                 w_lfsr_fb;

    maj_popcount #(
        .N (N)
    ) u_popcount (
        .in  (r_x),
        .cnt (w_cnt)
    );

    assign w_y_ref      = (w_cnt >= c_thresh);
    assign w_mismatch   = (y_in != w_y_ref);
    assign w_busy       = (r_state == ST_CORNER) || (r_state == ST_BOUND) || (r_state == ST_RAND);
    assign w_period_end = (r_settle == c_settle_max);
    assign w_lfsr_fb    = ^(r_lfsr & c_lfsr_taps);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Each compare edge also loads the next vector, so periods run back-to-back
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_cmp       = 1'b0;
        w_finish    = 1'b0;
        w_start_run = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_CORNER;
                    w_idx_nxt   = '0;
                end
            end
            ST_CORNER: begin
                if (w_period_end) begin
                    w_cmp  = 1'b1;
                    w_load = 1'b1;
                    if (r_idx == c_corner_last) begin
                        w_state_nxt = ST_BOUND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_BOUND: begin
                if (w_period_end) begin
                    w_cmp  = 1'b1;
                    w_load = 1'b1;
                    if (r_idx == c_bound_last) begin
                        w_state_nxt = ST_RAND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_RAND: begin
                if (w_period_end) begin
                    w_cmp = 1'b1;
                    if (r_idx == c_rand_last) begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_load    = 1'b1;
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Boundary index: bit 0 picks W22/W23, the rest is the rotation amount
    always_comb begin
        w_rot_k = ROTW'(w_idx_nxt >> 1);
        w_vec   = r_x;
        case (w_state_nxt)
            ST_CORNER: w_vec = {N{w_idx_nxt[0]}};
            ST_BOUND:  w_vec = rotl(w_idx_nxt[0] ? c_w23 : c_w22, w_rot_k);
            ST_RAND:   w_vec = r_lfsr;
            default:   w_vec = r_x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_settle     <= '0;
            r_lfsr       <= c_seed;
            r_x          <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_pass       <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;

            if (w_start_run) begin
                r_lfsr <= c_seed;
            end else if (w_load && (w_state_nxt == ST_RAND)) begin
                r_lfsr <= {r_lfsr[N-2:0], w_lfsr_fb};
            end

            if (w_load) begin
                r_x      <= w_vec;
                r_settle <= '0;
            end else if (w_busy && !w_period_end) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_start_run) begin
                r_err        <= '0;
                r_fail_valid <= 1'b0;
                r_fail_vec   <= '0;
                r_pass       <= 1'b0;
            end

            if (w_cmp && w_mismatch) begin
                if (r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_vec   <= r_x;
                end
            end

            if (w_finish) begin
                r_pass <= (r_err == '0) && !w_mismatch;
            end
        end
    end

    assign x_out      = r_x;
    assign busy       = w_busy;
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_maj_bist_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_maj_bist_driver                                           |
// | Description : Scoreboard bench for maj_bist_driver with a faultable       |
// |               majority-gate stand-in driving y_in.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_maj_bist_driver;

    localparam int TN      = 45;
    localparam int TTH     = 23;
    localparam int TRAND   = 4096;
    localparam int TP      = 2;
    localparam int TV      = 2 + 2 * TN + TRAND;

    typedef struct {
        logic [15:0]   err;
        logic          fv;
        logic [TN-1:0] fvec;
        logic          pass;
        logic [TN-1:0] last;
    } res_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TN-1:0] x_out;
    logic          y_in;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic          fail_valid;
    logic [TN-1:0] fail_vec;

    int mode;
    int fsel;
    int checks   = 0;
    int failures = 0;

    logic [TN-1:0] vecs[$];
    logic [TN-1:0] vq[$];
    res_t          rq[$];

    maj_bist_driver dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_out      (x_out),
        .y_in       (y_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Majority gate under test: 0 good, 1 stuck-0, 2 threshold 22, 3 inverted, 4 popcount-class flips
    function automatic logic dut_y(input int m, input int sel, input logic [TN-1:0] v);
        int c;
        c = $countones(v);
        case (m)
            0:       return c >= 23;
            1:       return 1'b0;
            2:       return c >= 22;
            3:       return !(c >= 23);
            default: return (c >= 23) ^ ((c % 5) == sel);
        endcase
    endfunction

    assign y_in = dut_y(mode, fsel, x_out);

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic build_vectors();
        logic [TN-1:0] w;
        logic [TN-1:0] s;
        logic          fb;
        vecs.push_back('0);
        vecs.push_back('1);
        for (int k = 0; k < TN; k++) begin
            for (int t = 0; t < 2; t++) begin
                w = '0;
                for (int i = 0; i < TTH - 1 + t; i++) w[(i + k) % TN] = 1'b1;
                vecs.push_back(w);
            end
        end
        s = 45'h1;
        for (int r = 0; r < TRAND; r++) begin
            vecs.push_back(s);
            fb = s[44] ^ s[43] ^ s[41] ^ s[40];
            s  = {s[43:0], fb};
        end
    endtask

    task automatic do_run(input int m, input int sel, input bit stray, input int abort_at);
        res_t r;
        int   e;
        int   to;
        int   p;
        bit   got;
        logic yref;
        mode = m;
        fsel = sel;
        e    = 0;
        got  = 1'b0;
        r.fvec = '0;
        foreach (vecs[i]) begin
            yref = ($countones(vecs[i]) >= TTH);
            if (dut_y(m, sel, vecs[i]) != yref) begin
                if (e < 65535) e++;
                if (!got) begin
                    got    = 1'b1;
                    r.fvec = vecs[i];
                end
            end
            vq.push_back(vecs[i]);
        end
        r.err  = 16'(e);
        r.fv   = got;
        r.pass = (e == 0);
        r.last = vecs[TV-1];
        if (abort_at == 0) rq.push_back(r);

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            return;
        end

        p  = $urandom_range(20, 8300);
        to = 0;
        while (done !== 1'b1 && to < 9000) begin
            @(posedge clk); #1;
            to++;
            if (stray && to == p)     start = 1'b1;
            if (stray && to == p + 1) start = 1'b0;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=done_low required=done_high mode=%0d", m);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    int            cyc = 0;
    int            t0  = 0;
    bit            tracking  = 1'b0;
    bit            prev_busy = 1'b0;
    bit            prev_done = 1'b0;
    bit            rst_d     = 1'b0;

    always @(negedge clk) begin
        logic [TN-1:0] v;
        res_t          r;
        if (rst_d) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_pass", 64'(pass), 64'd0);
            chk("rst_err", 64'(err_count), 64'd0);
            chk("rst_fail_valid", 64'(fail_valid), 64'd0);
            chk("rst_fail_vec", 64'(fail_vec), 64'd0);
            chk("rst_x_out", 64'(x_out), 64'd0);
        end
        rst_d = rst;
        if (rst) begin
            tracking  = 1'b0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
            vq.delete();
            rq.delete();
        end else begin
            if (busy && !prev_busy) begin
                tracking = 1'b1;
                t0       = cyc;
                chk("start_err_clear", 64'(err_count), 64'd0);
                chk("start_fail_valid_clear", 64'(fail_valid), 64'd0);
                chk("start_done_clear", 64'(done), 64'd0);
                chk("start_pass_clear", 64'(pass), 64'd0);
            end
            if (tracking && busy && ((cyc - t0) % TP == 0)) begin
                if (vq.size() == 0) begin
                    chk("vec_underflow", 64'd1, 64'd0);
                end else begin
                    v = vq.pop_front();
                    chk("x_out_vec", 64'(x_out), 64'(v));
                end
            end
            if (tracking && done && !prev_done) begin
                tracking = 1'b0;
                chk("run_length", 64'(cyc - t0), 64'(TV * TP));
                chk("vec_left", 64'(vq.size()), 64'd0);
                vq.delete();
                if (rq.size() == 0) begin
                    chk("result_underflow", 64'd1, 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("err_count", 64'(err_count), 64'(r.err));
                    chk("fail_valid", 64'(fail_valid), 64'(r.fv));
                    chk("fail_vec", 64'(fail_vec), 64'(r.fvec));
                    chk("pass", 64'(pass), 64'(r.pass));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("x_out_hold", 64'(x_out), 64'(r.last));
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
        cyc++;
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        fsel  = 0;
        build_vectors();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_run(0, 0, 1'b1, 0);
        do_run(1, 0, 1'b0, 0);
        do_run(2, 0, 1'b0, 0);
        do_run(3, 0, 1'b0, 0);
        do_run(3, 0, 1'b0, 100);
        do_run(3, 0, 1'b0, 0);
        do_run(4, $urandom_range(0, 4), 1'b1, 0);
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
